// File: rtl/pipelined_ripple_adder.sv
//------------------------------------------------------------------------------
// Module      : pipelined_ripple_adder
// Description : WIDTH-bit add/subtract unit built from SEG-bit ripple segments
//               with registered inter-segment carries, operand skew, result
//               deskew, valid pipeline, global stall and signed-overflow flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipelined_ripple_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  localparam int NSTAGES = WIDTH / SEG;

  if (WIDTH % SEG != 0) begin : g_param_check
    $error("pipelined_ripple_adder: WIDTH must be a multiple of SEG");
  end

  // Subtraction is a + ~b + 1, so the segments only ever add.
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;

  assign w_b_eff = sub ? ~b : b;
  assign w_c0    = sub | cin;

  wire  [SEG-1:0]     w_seg_out [NSTAGES];
  wire  [NSTAGES-1:0] w_cy;
  wire                w_ovf;
  logic [NSTAGES-1:0] r_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (en) begin
      r_valid[0] <= in_valid;
      for (int s = 1; s < NSTAGES; s++) begin
        r_valid[s] <= r_valid[s-1];
      end
    end
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_seg
    logic [SEG-1:0] w_op_a;
    logic [SEG-1:0] w_op_b;
    logic           w_cin;
    logic [SEG-1:0] w_sum;
    logic [SEG:0]   w_c;
    logic           r_cy;
    logic [SEG-1:0] r_dsk [NSTAGES-k];

    if (k == 0) begin : g_in
      assign w_op_a = a[SEG-1:0];
      assign w_op_b = w_b_eff[SEG-1:0];
      assign w_cin  = w_c0;
    end else begin : g_skew
      // k-deep operand delay so this slice meets the carry from segment k-1
      logic [SEG-1:0] r_a [k];
      logic [SEG-1:0] r_b [k];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int j = 0; j < k; j++) begin
            r_a[j] <= '0;
            r_b[j] <= '0;
          end
        end else if (en) begin
          r_a[0] <= a[k*SEG +: SEG];
          r_b[0] <= w_b_eff[k*SEG +: SEG];
          for (int j = 1; j < k; j++) begin
            r_a[j] <= r_a[j-1];
            r_b[j] <= r_b[j-1];
          end
        end
      end

      assign w_op_a = r_a[k-1];
      assign w_op_b = r_b[k-1];
      assign w_cin  = w_cy[k-1];
    end

    always_comb begin
      w_c    = '0;
      w_sum  = '0;
      w_c[0] = w_cin;
      for (int i = 0; i < SEG; i++) begin
        w_sum[i]   = w_op_a[i] ^ w_op_b[i] ^ w_c[i];
        w_c[i+1]   = (w_op_a[i] & w_op_b[i]) | (w_c[i] & (w_op_a[i] ^ w_op_b[i]));
      end
    end

    // r_dsk[0] is the segment's own stage register; the rest is deskew.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cy <= 1'b0;
        for (int j = 0; j < NSTAGES - k; j++) begin
          r_dsk[j] <= '0;
        end
      end else if (en) begin
        r_cy     <= w_c[SEG];
        r_dsk[0] <= w_sum;
        for (int j = 1; j < NSTAGES - k; j++) begin
          r_dsk[j] <= r_dsk[j-1];
        end
      end
    end

    assign w_seg_out[k] = r_dsk[NSTAGES-1-k];
    assign w_cy[k]      = r_cy;

    if (k == NSTAGES - 1) begin : g_flags
      // b is already inverted in subtract mode, so this holds for both modes.
      logic r_ovf;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_ovf <= 1'b0;
        end else if (en) begin
          r_ovf <= w_c[SEG] ^ w_c[SEG-1];
        end
      end

      assign w_ovf = r_ovf;
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < NSTAGES; k++) begin
      sum[k*SEG +: SEG] = w_seg_out[k];
    end
  end

  assign cout      = w_cy[NSTAGES-1];
  assign ovf       = w_ovf;
  assign out_valid = r_valid[NSTAGES-1];

endmodule

`default_nettype wire

// File: doc/pipelined_ripple_adder.md
Name: pipelined_ripple_adder

Overview:
- Parametrised successor to the 4-bit registered-carry ripple adder.
- WIDTH-bit add/subtract unit split into NSTAGES = WIDTH/SEG ripple-carry segments, with the inter-segment carry registered between stages.
- Adds operand skew and result deskew registers, a valid pipeline, a global stall, subtract mode and a signed-overflow flag, so one operation enters per cycle.
- Sits in the datapath as the team's generic pipelined adder.

Parameters:
- WIDTH, 16, operand/result width in bits.
- SEG, 4, bits per pipeline segment. WIDTH % SEG != 0 is an elaboration error. NSTAGES = WIDTH/SEG.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low: rst=0 resets, rst=1 runs.
- en  input  1  pipeline advance. When 0, every register holds.
- in_valid  input  1  operands valid this cycle.
- sub  input  1  0 = add a+b+cin; 1 = subtract a-b (cin ignored).
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in, used only when sub=0.
- sum  output  WIDTH  result.
- cout  output  1  carry-out. In subtract mode, 1 = no borrow (a >= b unsigned).
- ovf  output  1  signed overflow.
- out_valid  output  1  sum/cout/ovf hold a valid result.

Behaviour:
- Reset:
  - rst=0 asynchronously clears every register: sum=0, cout=0, ovf=0, out_valid=0, all skew/deskew/carry/valid registers 0.
  - Applies mid-operation; in-flight operations are discarded.
  - Release is sampled on the next rising edge.
- Operand preprocessing (combinational, stage 0 input):
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
- Segment k (0..NSTAGES-1):
  - Adds a[k*SEG +: SEG] + b_eff[k*SEG +: SEG] + carry_k through a SEG-bit full-adder ripple chain.
  - carry_0 = c0. carry_k for k>0 is stage k-1's registered carry-out.
- Skew: segment k's operand bits are delayed k register stages so they meet their carry.
- Deskew: segment k's sum bits are delayed NSTAGES-1-k further stages so all segments emerge together.
- Valid: one valid bit per stage travels with the data. in_valid=0 injects a bubble; data registers still load when en=1, but their contents are don't-care.
- Latency:
  - Operands sampled at rising edge n (en=1) appear on the outputs right after edge n+NSTAGES-1, provided en=1 at every intervening edge.
  - NSTAGES=1 gives a plain registered adder with latency 1.
- Throughput: one operation per cycle; back-to-back in_valid=1 with no gaps.
- Stall: en=0 freezes every register, including the outputs and out_valid; inputs are ignored. Each en=0 edge adds one cycle to the latency of in-flight operations. Results are never dropped or duplicated.
- Flags, registered with sum:
  - cout = carry out of MSB.
  - ovf = carry into MSB XOR carry out of MSB.
  - sub mode and the carry-into-MSB needed for ovf travel with the last segment.
- Outputs are fully registered; no combinational path from inputs to outputs.
- Simultaneous events:
  - rst=0 overrides en and in_valid.
  - en=0 overrides in_valid; an operation presented while en=0 is not captured.
- Wrap-around: sum is modulo 2^WIDTH; overflow is reported only through cout/ovf.

Test Plan (WIDTH=16, SEG=4, latency 4):
1. Reset: assert rst=0 with random inputs toggling → sum=0x0000, cout=0, ovf=0, out_valid=0 throughout. Release rst=1 with in_valid=0 → out_valid stays 0.
2. Full carry ripple across every segment: a=0xFFFF, b=0x0001, cin=0, sub=0 at edge n → after edge n+3: sum=0x0000, cout=1, ovf=0, out_valid=1 for exactly one cycle.
3. Back-to-back, one per cycle:
   - 0x7FFF+0x0001 → sum 0x8000, cout=0, ovf=1.
   - 0x1234+0x4321, cin=1 → sum 0x5556, cout=0, ovf=0.
   - Bubble (in_valid=0) → out_valid=0.
   - 0x8000+0x8000 → sum 0x0000, cout=1, ovf=1.
   - All appear on consecutive cycles in order, with the bubble preserved.
4. Subtract:
   - 0x0005-0x0007 (cin=1, ignored) → sum 0xFFFE, cout=0, ovf=0.
   - 0x8000-0x0001 → sum 0x7FFF, cout=1, ovf=1.
   - 0x1234-0x1234 → sum 0x0000, cout=1, ovf=0.
5. Stall: launch 0x00FF+0x0001 at edge n, then hold en=0 for 3 edges starting n+1 → outputs frozen during the stall; sum=0x0100 appears after edge n+6, once, with out_valid=1.
6. Reset mid-flight: launch 3 operations, pull rst=0 for 1 cycle after the second edge → out_valid drops to 0 immediately (asynchronously). After release with in_valid=0, no stale result ever emerges.
